// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings
// and the default debounce length for the 50 MHz board clock.
package button_conditioner_pkg;

  localparam logic [1:0] ST_IDLE        = 2'b00;
  localparam logic [1:0] ST_DEB_PRESS   = 2'b01;
  localparam logic [1:0] ST_PRESSED     = 2'b10;
  localparam logic [1:0] ST_DEB_RELEASE = 2'b11;

  localparam int unsigned CLK_HZ           = 50_000_000;
  // 10 ms worth of cycles at CLK_HZ
  localparam int unsigned DEFAULT_DEBOUNCE = CLK_HZ / 100;

  typedef enum logic [1:0] {
    IDLE        = ST_IDLE,
    DEB_PRESS   = ST_DEB_PRESS,
    PRESSED     = ST_PRESSED,
    DEB_RELEASE = ST_DEB_RELEASE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset
// value lets callers park the chain at the pin's inactive level.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Turns a raw, bouncing push-button pin into a debounced level and a single
// one-cycle pulse per accepted press, for stepping the state counter.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_raw,
  output logic botao_pulse,
  output logic botao_level,
  output logic busy
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s2;
  logic          pressed_s;
  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          next_pulse;

  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (botao_raw),
    .q    (s2)
  );

  assign pressed_s = s2 ^ ACTIVE_LOW;

  // Counter only runs inside the debounce states and is cleared on every
  // state change, so it can never wrap.
  always_comb begin
    next_state = state;
    next_count = count;
    next_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (pressed_s) begin
          next_state = DEB_PRESS;
          next_count = '0;
        end
      end
      DEB_PRESS: begin
        if (!pressed_s) begin
          next_state = IDLE;
          next_count = '0;
        end else if (count == LAST) begin
          next_state = PRESSED;
          next_count = '0;
          next_pulse = 1'b1;
        end else begin
          next_count = count + CW'(1);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          next_state = DEB_RELEASE;
          next_count = '0;
        end
      end
      DEB_RELEASE: begin
        // A re-press here is release bounce: back to PRESSED with no pulse.
        if (pressed_s) begin
          next_state = PRESSED;
          next_count = '0;
        end else if (count == LAST) begin
          next_state = IDLE;
          next_count = '0;
        end else begin
          next_count = count + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      botao_pulse <= 1'b0;
      botao_level <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      count       <= next_count;
      botao_pulse <= next_pulse;
      botao_level <= (next_state == PRESSED) || (next_state == DEB_RELEASE);
      busy        <= (next_state == DEB_PRESS) || (next_state == DEB_RELEASE);
    end
  end

endmodule
